mvu_job_sched: RTL
==================

Name: mvu_job_sched

Overview:
- Job scheduler in front of the MVU array. Accepts job descriptors into a small FIFO and dispatches each one to an idle MVU allowed by the job's MVU mask, using round-robin selection.
- For each dispatch it writes the descriptor into that MVU's config slot, then pulses that MVU's start.
- Tracks per-MVU busy state from start to done, and reports completions, errors and global idle to the host/CSR layer.

Parameters:
- NMVU, 8, number of MVUs scheduled.
- DESC_W, 64, job descriptor width; opaque to this block.
- QDEPTH, 4, descriptor FIFO depth; power of two, >=2.
- WDOG_W, 24, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- enq_valid  in  1  descriptor offered.
- enq_ready  out  1  FIFO can accept; equals !full.
- enq_desc  in  DESC_W  descriptor.
- enq_mask  in  NMVU  MVUs eligible to run this job.
- cfg_desc  out  NMVU*DESC_W  per-MVU latched descriptor; slice i feeds MVU i.
- cfg_we  out  NMVU  one-cycle pulse when slice i is rewritten.
- start  out  NMVU  one-cycle start pulse to MVU i.
- done  in  NMVU  one-cycle completion pulse from MVU i.
- busy  out  NMVU  MVU i is running a scheduled job.
- cmpl  out  NMVU  registered completion notify; one-cycle pulse.
- jobs_done  out  16  completed-job counter; wraps.
- idle  out  1  FIFO empty, no MVU busy, FSM in S_IDLE.
- err_clr  in  1  clears sticky errors.
- err_badmask  out  1  sticky: a descriptor was enqueued with an all-zero mask.
- err_spurious  out  1  sticky: done seen on a non-busy MVU.

Behaviour:
- Reset (synchronous, active-high). While rst is high and on the first cycle after:
  - FIFO empty, FSM = S_IDLE, rr_ptr = 0, jobs_done = 0.
  - All cfg_desc = 0; cfg_we, start, busy, cmpl = 0; errors = 0.
  - enq_ready = 0 while rst is high, 1 from the cycle after rst falls; idle = 1 from that same cycle.
  - Reset mid-job abandons all state; later done pulses count as spurious.
- Enqueue:
  - A transfer occurs when enq_valid && enq_ready at the clock edge.
  - If enq_mask == 0, the descriptor is dropped (not stored) and err_badmask is set.
  - When full, enq_ready = 0 and nothing is stored.
  - Simultaneous push and pop while full is not allowed: ready is already low.
- FSM:
  - S_IDLE: elig = head_mask & ~busy, computed when the FIFO is non-empty. If elig != 0, sel = first set bit of elig searching circularly from rr_ptr upward. Latch sel; go to S_CFG. Otherwise stay: head-of-line blocking, later jobs wait.
  - S_CFG: cfg_desc[sel] <= head_desc; cfg_we[sel] = 1 for this cycle; go to S_START.
  - S_START: start[sel] = 1 for this cycle; busy[sel] <= 1; pop FIFO; rr_ptr <= (sel+1) mod NMVU; go to S_IDLE.
- Throughput and latency:
  - Peak throughput: one dispatch per 3 cycles.
  - Latency from a push into an empty FIFO with an idle eligible MVU to start: 3 cycles (push edge, S_IDLE, S_CFG, start asserted in S_START).
- Completion:
  - For each i with done[i] && busy[i]: busy[i] <= 0, and cmpl[i] <= 1 on the next cycle.
  - jobs_done += popcount(done & busy); multiple simultaneous completions are all counted.
  - done[i] && !busy[i] sets err_spurious. This includes done arriving on the same cycle start[i] is asserted, because busy[i] is not yet set.
  - A busy bit freed by done is usable by S_IDLE on the following cycle.
- Errors: err_clr clears both sticky errors. If err_clr and a new error event occur in the same cycle, the set wins.
- Arithmetic: jobs_done wraps 0xFFFF -> 0. rr_ptr is log2(NMVU) bits and wraps modulo NMVU.

Optional Feature:
- Macro: MVU_SCHED_WDOG_EN.
- Defined:
  - Extra ports: wdog_limit in WDOG_W, and wdog_to out NMVU (sticky per MVU, cleared by err_clr).
  - Per-MVU counter is zeroed on start and increments while busy.
  - When the counter reaches wdog_limit (wdog_limit != 0), busy[i] <= 0 and wdog_to[i] <= 1. No cmpl pulse and no jobs_done increment.
  - A later done from that MVU counts as spurious.
  - wdog_limit == 0 disables the watchdog.
- Undefined: those ports and counters do not exist; busy clears only on done.

Test Plan:
- Reset, then push desc=0x11 with mask=0x01 -> cfg_we=0x01 with cfg_desc[0]=0x11, next cycle start=0x01, busy=0x01. After done[0] pulse: cmpl=0x01 one cycle later, jobs_done=1, idle=1.
- Push 4 jobs with mask=0xFF, all MVUs idle -> starts go to MVU0,1,2,3 in order, 3 cycles apart. Then rr_ptr=4, and a 5th job goes to MVU4.
- Push 4 jobs with mask=0x01 while MVU0 stays busy -> FIFO full and enq_ready=0; a 5th push is not accepted. done[0] -> next job starts on MVU0, and enq_ready returns to 1 the cycle after the pop.
- Push mask=0x00 -> nothing dispatched, err_badmask=1, idle stays 1. err_clr -> err_badmask=0.
- done=0x06 on the same cycle with busy=0x06 -> jobs_done+=2, cmpl=0x06. Then done[5] with MVU5 idle -> err_spurious=1, jobs_done unchanged.
- (MVU_SCHED_WDOG_EN) wdog_limit=10, job on MVU2 with no done -> 10 cycles after start, busy[2]=0, wdog_to=0x04, jobs_done unchanged.

Source files
------------

// File: rtl/mvu_job_sched.sv
// mvu_job_sched: round-robin job scheduler dispatching queued descriptors to idle MVUs
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   enq_valid/enq_ready           descriptor enqueue handshake (ready = !full, low in reset)
//   enq_desc, enq_mask            descriptor and MVUs eligible to run it
//   cfg_desc, cfg_we              per-MVU latched descriptor slices and write pulses
//   start, done, busy, cmpl       per-MVU start pulse, completion input, busy state, completion notify
//   jobs_done, idle               completed-job counter (wraps), global idle
//   err_clr, err_badmask,
//   err_spurious                  sticky error flags and their clear
// Optional MVU_SCHED_WDOG_EN adds WDOG_W, wdog_limit and per-MVU sticky wdog_to.
module mvu_job_sched #(
    parameter int NMVU   = 8,
    parameter int DESC_W = 64,
    parameter int QDEPTH = 4
`ifdef MVU_SCHED_WDOG_EN
    ,
    parameter int WDOG_W = 24
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [DESC_W-1:0]      enq_desc,
    input  logic [NMVU-1:0]        enq_mask,
    output logic [NMVU*DESC_W-1:0] cfg_desc,
    output logic [NMVU-1:0]        cfg_we,
    output logic [NMVU-1:0]        start,
    input  logic [NMVU-1:0]        done,
    output logic [NMVU-1:0]        busy,
    output logic [NMVU-1:0]        cmpl,
    output logic [15:0]            jobs_done,
    output logic                   idle,
    input  logic                   err_clr,
    output logic                   err_badmask,
    output logic                   err_spurious
`ifdef MVU_SCHED_WDOG_EN
    ,
    input  logic [WDOG_W-1:0]      wdog_limit,
    output logic [NMVU-1:0]        wdog_to
`endif
);
    localparam int AW = $clog2(QDEPTH);
    localparam int PW = (NMVU > 1) ? $clog2(NMVU) : 1;
    localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);
    typedef enum logic [1:0] {S_IDLE, S_CFG, S_START} state_t;
    state_t state, state_nxt;
    logic [DESC_W-1:0] q_desc [QDEPTH];
    logic [NMVU-1:0]   q_mask [QDEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [PW-1:0]     rr_ptr, sel, pick;
    logic [NMVU-1:0]   elig, sel_oh, fin, tmo;
    logic              push, bad, pop;

    assign enq_ready = !rst && count != QFULL;
    assign push      = enq_valid && enq_ready && |enq_mask;
    assign bad       = enq_valid && enq_ready && !(|enq_mask);
    assign elig      = (count != '0) ? q_mask[rd_ptr] & ~busy : '0;
    assign sel_oh    = NMVU'(1) << sel;
    assign fin       = done & busy;
    assign idle      = state == S_IDLE && count == '0 && busy == '0;

    // Descending scan so the lowest circular offset from rr_ptr wins.
    always_comb begin
        pick = '0;
        for (int k = NMVU - 1; k >= 0; k--)
            if (elig[(int'(rr_ptr) + k) % NMVU]) pick = PW'((int'(rr_ptr) + k) % NMVU);
    end

    always_ff @(posedge clk)
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = (state == S_IDLE) ? (|elig ? S_CFG : S_IDLE) :
                    (state == S_CFG)  ? S_START : S_IDLE;
    end

    always_comb begin
        cfg_we = (state == S_CFG)   ? sel_oh : '0;
        start  = (state == S_START) ? sel_oh : '0;
        pop    = state == S_START;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rr_ptr       <= '0;
            sel          <= '0;
            cfg_desc     <= '0;
            busy         <= '0;
            cmpl         <= '0;
            jobs_done    <= '0;
            err_badmask  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (push) begin
                q_desc[wr_ptr] <= enq_desc;
                q_mask[wr_ptr] <= enq_mask;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (state == S_IDLE && |elig) sel <= pick;
            if (state == S_CFG) cfg_desc[sel*DESC_W +: DESC_W] <= q_desc[rd_ptr];
            if (pop) rr_ptr <= (sel == PW'(NMVU - 1)) ? '0 : sel + 1'b1;
            // Start on a cycle with a done for the same MVU still sets busy; that done is spurious.
            busy         <= (busy & ~done & ~tmo) | start;
            cmpl         <= fin;
            jobs_done    <= jobs_done + 16'($countones(fin));
            err_badmask  <= bad | (err_badmask & !err_clr);
            err_spurious <= |(done & ~busy) | (err_spurious & !err_clr);
        end
    end

`ifdef MVU_SCHED_WDOG_EN
    logic [WDOG_W-1:0] wcnt [NMVU];

    // Timeout fires on the edge where the count would reach the limit, so busy lasts wdog_limit cycles.
    always_comb begin
        tmo = '0;
        for (int i = 0; i < NMVU; i++)
            tmo[i] = busy[i] && !done[i] && wdog_limit != '0 && wcnt[i] + 1'b1 == wdog_limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_to <= '0;
            for (int i = 0; i < NMVU; i++) wcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NMVU; i++)
                wcnt[i] <= start[i] ? '0 : busy[i] ? wcnt[i] + 1'b1 : wcnt[i];
            wdog_to <= tmo | (wdog_to & ~{NMVU{err_clr}});
        end
    end
`else
    assign tmo = '0;
`endif
endmodule
